// File: rtl/fp_mul_normalize.sv
// Significand product and normalization ahead of the FP multiplier rounding stage.
// Defining FPU_NORM_SKID_EN adds a one-entry input skid buffer so that in_ready comes from a register.
module fp_mul_normalize #(
    parameter int BIAS  = 127,
    parameter int EXP_W = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             Sx,
    input  logic             Sy,
    input  logic [7:0]       Ex,
    input  logic [7:0]       Ey,
    input  logic [23:0]      Mx,
    input  logic [23:0]      My,
    input  logic [1:0]       R_mode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      After_norm,
    output logic             T,
    output logic             Sz,
    output logic [EXP_W-1:0] Ez,
    output logic             Zero,
    output logic [1:0]       R_mode_out
);
    // Handshake: a beat moves on a rising CLK edge where valid & ready are both high; the sender
    // holds valid and payload steady until then, and outputs stay frozen while out_ready is low.

    localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);

    logic             s1_valid;
    logic [47:0]      s1_p;
    logic [EXP_W-1:0] s1_e;
    logic             s1_s;
    logic             s1_z;
    logic [1:0]       s1_rm;

    logic adv2;
    logic s1_free;
    logic in_fire;
    logic s1_load;

    assign adv2    = ~out_valid | out_ready;
    assign s1_free = ~s1_valid | adv2;
    assign in_fire = in_valid & in_ready;

    logic [47:0]      in_p;
    logic [EXP_W-1:0] in_e;
    logic             in_s;
    logic             in_z;

    assign in_p = {24'd0, Mx} * {24'd0, My};
    assign in_e = EXP_W'(Ex) + EXP_W'(Ey) - BIAS_E;
    assign in_s = Sx ^ Sy;
    assign in_z = (Mx == 24'd0) | (My == 24'd0);

    logic [47:0]      ld_p;
    logic [EXP_W-1:0] ld_e;
    logic             ld_s;
    logic             ld_z;
    logic [1:0]       ld_rm;

`ifdef FPU_NORM_SKID_EN
    logic             sk_valid;
    logic [47:0]      sk_p;
    logic [EXP_W-1:0] sk_e;
    logic             sk_s;
    logic             sk_z;
    logic [1:0]       sk_rm;

    assign in_ready = ~sk_valid;
    assign s1_load  = s1_free & (sk_valid | in_fire);
    assign ld_p     = sk_valid ? sk_p  : in_p;
    assign ld_e     = sk_valid ? sk_e  : in_e;
    assign ld_s     = sk_valid ? sk_s  : in_s;
    assign ld_z     = sk_valid ? sk_z  : in_z;
    assign ld_rm    = sk_valid ? sk_rm : R_mode_in;

    // The skid entry always drains into S1 before any new operand can be accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sk_valid <= 1'b0;
            sk_p     <= '0;
            sk_e     <= '0;
            sk_s     <= 1'b0;
            sk_z     <= 1'b0;
            sk_rm    <= '0;
        end else if (sk_valid) begin
            if (s1_free) sk_valid <= 1'b0;
        end else if (in_fire & ~s1_free) begin
            sk_valid <= 1'b1;
            sk_p     <= in_p;
            sk_e     <= in_e;
            sk_s     <= in_s;
            sk_z     <= in_z;
            sk_rm    <= R_mode_in;
        end
    end
`else
    assign in_ready = s1_free;
    assign s1_load  = in_fire;
    assign ld_p     = in_p;
    assign ld_e     = in_e;
    assign ld_s     = in_s;
    assign ld_z     = in_z;
    assign ld_rm    = R_mode_in;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_e     <= '0;
            s1_s     <= 1'b0;
            s1_z     <= 1'b0;
            s1_rm    <= '0;
        end else begin
            if (s1_free) s1_valid <= s1_load;
            if (s1_load) begin
                s1_p  <= ld_p;
                s1_e  <= ld_e;
                s1_s  <= ld_s;
                s1_z  <= ld_z;
                s1_rm <= ld_rm;
            end
        end
    end

    logic [24:0]      n_an;
    logic             n_t;
    logic [EXP_W-1:0] n_e;

    // A product of two [1,2) significands lies in [1,4): at most one right shift is needed.
    always_comb begin
        n_an = '0;
        n_t  = 1'b0;
        n_e  = '0;
        if (!s1_z) begin
            if (s1_p[47]) begin
                n_an = s1_p[47:23];
                n_t  = |s1_p[22:0];
                n_e  = s1_e + EXP_W'(1);
            end else begin
                n_an = s1_p[46:22];
                n_t  = |s1_p[21:0];
                n_e  = s1_e;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid  <= 1'b0;
            After_norm <= '0;
            T          <= 1'b0;
            Sz         <= 1'b0;
            Ez         <= '0;
            Zero       <= 1'b0;
            R_mode_out <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                After_norm <= n_an;
                T          <= n_t;
                Sz         <= s1_s;
                Ez         <= n_e;
                Zero       <= s1_z;
                R_mode_out <= s1_rm;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Directed and randomized-backpressure bench for fp_mul_normalize.
// Expected results come from hand-computed constants and an independent shift-based model.
module tb_fp_mul_normalize;
`ifdef FPU_NORM_SKID_EN
    localparam int CAP = 3;
`else
    localparam int CAP = 2;
`endif

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic        Sx;
    logic        Sy;
    logic [7:0]  Ex;
    logic [7:0]  Ey;
    logic [23:0] Mx;
    logic [23:0] My;
    logic [1:0]  R_mode_in;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] After_norm;
    logic        T;
    logic        Sz;
    logic [9:0]  Ez;
    logic        Zero;
    logic [1:0]  R_mode_out;

    fp_mul_normalize #(.BIAS(127), .EXP_W(10)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Sx         (Sx),
        .Sy         (Sy),
        .Ex         (Ex),
        .Ey         (Ey),
        .Mx         (Mx),
        .My         (My),
        .R_mode_in  (R_mode_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .After_norm (After_norm),
        .T          (T),
        .Sz         (Sz),
        .Ez         (Ez),
        .Zero       (Zero),
        .R_mode_out (R_mode_out)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    logic        sb_en = 1'b0;
    logic [39:0] exp_q[$];
    logic [39:0] obs;

    assign obs = {R_mode_out, Zero, Sz, Ez, T, After_norm};

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: shift the full product right by 23 or 22 and OR the discarded bits.
    function automatic logic [39:0] model(input logic sx, input logic sy, input logic [7:0] ex,
                                          input logic [7:0] ey, input logic [23:0] mx,
                                          input logic [23:0] my, input logic [1:0] rm);
        logic [47:0] p;
        logic [24:0] an;
        logic        t;
        logic [9:0]  ez;
        logic        z;
        int          sh;
        p  = 48'(mx) * 48'(my);
        z  = (mx == 24'd0) || (my == 24'd0);
        ez = 10'(ex) + 10'(ey) - 10'd127;
        sh = (p >= 48'h8000_0000_0000) ? 23 : 22;
        if (sh == 23) ez = ez + 10'd1;
        an = 25'(p >> sh);
        t  = (p & ((48'd1 << sh) - 48'd1)) != 48'd0;
        if (z) begin
            an = '0;
            t  = 1'b0;
            ez = '0;
        end
        return {rm, z, sx ^ sy, ez, t, an};
    endfunction

    // Scoreboard: every output transfer must match the head of the expected queue.
    always @(negedge CLK) begin
        if (sb_en && !RST && out_valid && out_ready) begin
            check("sb_nonempty", 40'(exp_q.size() != 0), 40'd1);
            if (exp_q.size() != 0) check("sb_data", obs, exp_q.pop_front());
        end
    end

    task automatic drive_op(input logic sx, input logic sy, input logic [7:0] ex,
                            input logic [7:0] ey, input logic [23:0] mx, input logic [23:0] my,
                            input logic [1:0] rm);
        Sx = sx; Sy = sy; Ex = ex; Ey = ey; Mx = mx; My = my; R_mode_in = rm;
    endtask

    task automatic drive_rand();
        Sx = 1'($urandom_range(0, 1));
        Sy = 1'($urandom_range(0, 1));
        Ex = 8'($urandom_range(1, 254));
        Ey = 8'($urandom_range(1, 254));
        Mx = ($urandom_range(0, 9) == 0) ? 24'd0 : {1'b1, 23'($urandom_range(0, 32'h7FFFFF))};
        My = ($urandom_range(0, 9) == 0) ? 24'd0 : {1'b1, 23'($urandom_range(0, 32'h7FFFFF))};
        R_mode_in = 2'($urandom_range(0, 3));
    endtask

    // Single operand through an empty pipeline with out_ready high; checks 2-cycle latency and fields.
    task automatic run_one(input string tag, input logic sx, input logic sy, input logic [7:0] ex,
                           input logic [7:0] ey, input logic [23:0] mx, input logic [23:0] my,
                           input logic [1:0] rm, input logic [24:0] e_an, input logic e_t,
                           input logic e_sz, input logic [9:0] e_ez, input logic e_zero);
        drive_op(sx, sy, ex, ey, mx, my, rm);
        in_valid = 1'b1;
        @(negedge CLK);
        check({tag, "_in_ready"}, 40'(in_ready), 40'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        check({tag, "_lat1"}, 40'(out_valid), 40'd0);
        @(negedge CLK);
        check({tag, "_lat2"}, 40'(out_valid), 40'd1);
        check({tag, "_an"}, 40'(After_norm), 40'(e_an));
        check({tag, "_t"}, 40'(T), 40'(e_t));
        check({tag, "_sz"}, 40'(Sz), 40'(e_sz));
        check({tag, "_ez"}, 40'(Ez), 40'(e_ez));
        check({tag, "_zero"}, 40'(Zero), 40'(e_zero));
        check({tag, "_rm"}, 40'(R_mode_out), 40'(rm));
        @(posedge CLK); #1;
    endtask

    initial begin
        int n_acc;
        int cyc;
        int sent;
        int k;
        int n_ov;
        logic acc;

        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive_op(1'b0, 1'b0, 8'd0, 8'd0, 24'd0, 24'd0, 2'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_out_valid", 40'(out_valid), 40'd0);
        check("reset_in_ready", 40'(in_ready), 40'd1);
        check("reset_fields", obs, 40'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // 1.0*1.0, 1.5*1.5, (1+2^-23)^2 with sign, zero operands, small and large exponents
        run_one("one", 0, 0, 8'd127, 8'd127, 24'h800000, 24'h800000, 2'd0, 25'h1000000, 0, 0, 10'd127, 0);
        run_one("onefive", 0, 0, 8'd127, 8'd127, 24'hC00000, 24'hC00000, 2'd1, 25'h1200000, 0, 0, 10'd128, 0);
        run_one("sticky", 1, 0, 8'd127, 8'd127, 24'h800001, 24'h800001, 2'd2, 25'h1000004, 1, 1, 10'd127, 0);
        run_one("zero_pp", 1, 1, 8'd127, 8'd127, 24'h000000, 24'hABCDEF, 2'd3, 25'h0, 0, 0, 10'd0, 1);
        run_one("zero_neg", 1, 0, 8'd200, 8'd50, 24'hFFFFFF, 24'h000000, 2'd0, 25'h0, 0, 1, 10'd0, 1);
        run_one("exp_low", 0, 0, 8'd1, 8'd1, 24'h800000, 24'h800000, 2'd1, 25'h1000000, 0, 0, 10'h383, 0);
        run_one("max", 0, 1, 8'd254, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 2'd2, 25'h1FFFFFC, 1, 1, 10'h17E, 0);

        // Backpressure: offer 4 operands with out_ready low; only CAP fit.
        sb_en = 1'b1;
        out_ready = 1'b0;
        n_acc = 0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            drive_op(k[0], 1'b0, 8'(100 + k), 8'd120, 24'h800000 | 24'(k * 24'h012345), 24'hA00000, 2'(k));
            in_valid = 1'b1;
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK); #1;
            if (acc) begin
                exp_q.push_back(model(Sx, Sy, Ex, Ey, Mx, My, R_mode_in));
                n_acc++;
                k++;
            end
        end
        in_valid = 1'b0;
        @(negedge CLK);
        check("bp_accepted", 40'(n_acc), 40'(CAP));
        check("bp_in_ready", 40'(in_ready), 40'd0);
        check("bp_hold_valid", 40'(out_valid), 40'd1);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("bp_drained", 40'(exp_q.size()), 40'd0);

        // Random out_ready over 200 operands
        sent = 0;
        cyc = 0;
        while ((sent < 200 || exp_q.size() != 0) && cyc < 5000) begin
            if (!in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
                drive_rand();
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge CLK);
            acc = in_valid && in_ready;
            @(posedge CLK); #1;
            if (acc) begin
                exp_q.push_back(model(Sx, Sy, Ex, Ey, Mx, My, R_mode_in));
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_sent", 40'(sent), 40'd200);
        check("rand_drained", 40'(exp_q.size()), 40'd0);

        // Reset with both stages full: nothing in flight may reappear.
        out_ready = 1'b0;
        n_acc = 0;
        cyc = 0;
        exp_q.delete();
        while (n_acc < CAP && cyc < 10) begin
            drive_op(1'b1, 1'b0, 8'd130, 8'd140, 24'hC00000, 24'hE00000, 2'd3);
            in_valid = 1'b1;
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK); #1;
            if (acc) n_acc++;
            cyc++;
        end
        in_valid = 1'b0;
        @(negedge CLK);
        check("rst_full", 40'(in_ready), 40'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_out_valid", 40'(out_valid), 40'd0);
        check("rst_in_ready", 40'(in_ready), 40'd1);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (out_valid) n_ov++;
        end
        check("rst_no_stale", 40'(n_ov), 40'd0);
        @(posedge CLK); #1;
        sb_en = 1'b0;
        run_one("post_rst", 0, 1, 8'd127, 8'd127, 24'hC00000, 24'h800000, 2'd2, 25'h1800000, 0, 1, 10'd127, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
